// File: rtl/servo_pwm_capture.sv
// Servo PWM capture: measures pulse width and frame period, decodes angle 0..180.
// Optional glitch filter enabled by defining SERVO_CAPTURE_GLITCH_FILTER_EN.
module servo_pwm_capture #(
    parameter int MIN_WIDTH  = 100000,
    parameter int MAX_WIDTH  = 200000,
    parameter int STEP       = 555,
    parameter int TIMEOUT    = 4000000,
    parameter int FILTER_LEN = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        pwm_in,
    output logic [21:0] width,
    output logic [21:0] period,
    output logic [8:0]  angle,
    output logic        valid,
    output logic        range_err,
    output logic        timeout
);
    localparam int CW      = 22;
    localparam int ARM_LEN = FILTER_LEN + 3;
    localparam int AW      = $clog2(ARM_LEN + 1);

    typedef enum logic [1:0] {WAIT_RISE, MEAS_HIGH, MEAS_LOW} mstate_t;
    typedef enum logic [1:0] {C_IDLE, C_DIV, C_DONE} cstate_t;

    mstate_t mstate_q, mstate_d;
    cstate_t cstate_q, cstate_d;
    logic sync1_q, sync2_q, prev_q, lvl;
    logic [AW-1:0] arm_q;
    logic armed, rise, fall, tmo_hit;
    logic load_cnt, start_conv, frame_end, div_step, conv_done, w_low, w_high;
    logic [CW-1:0] hcnt_q, pcnt_q, tcnt_q, hlat_q, rem_q;
    logic [7:0] quo_q;
    logic cerr_q;
    logic [21:0] width_q, period_q;
    logic [8:0] angle_q;
    logic valid_q, rerr_q, tmo_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef SERVO_CAPTURE_GLITCH_FILTER_EN
    localparam int FCW = $clog2(FILTER_LEN + 1);
    logic filt_q;
    logic [FCW-1:0] fcnt_q;

    // Flip the accepted level only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            filt_q <= 1'b0;
            fcnt_q <= '0;
        end else if (sync2_q == filt_q) begin
            fcnt_q <= '0;
        end else if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
            filt_q <= sync2_q;
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_q + 1'b1;
        end
    end
    assign lvl = filt_q;
`else
    assign lvl = sync2_q;
`endif

    // Edges are ignored until the conditioned level has settled after reset,
    // so an input already high at release is not taken as a rising edge.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            arm_q  <= '0;
            prev_q <= 1'b0;
        end else begin
            prev_q <= lvl;
            if (!armed) arm_q <= arm_q + 1'b1;
        end
    end
    assign armed   = (arm_q == AW'(ARM_LEN));
    assign rise    = armed & lvl & ~prev_q;
    assign fall    = armed & ~lvl & prev_q;
    assign tmo_hit = (mstate_q != WAIT_RISE) && !rise && !fall &&
                     (tcnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) mstate_q <= WAIT_RISE;
        else      mstate_q <= mstate_d;
    end

    always_comb begin
        mstate_d = mstate_q;
        case (mstate_q)
            WAIT_RISE: if (rise) mstate_d = MEAS_HIGH;
            MEAS_HIGH: if (tmo_hit) mstate_d = WAIT_RISE;
                       else if (fall) mstate_d = MEAS_LOW;
            MEAS_LOW:  if (tmo_hit) mstate_d = WAIT_RISE;
                       else if (rise) mstate_d = MEAS_HIGH;
            default:   mstate_d = WAIT_RISE;
        endcase
    end

    always_comb begin
        load_cnt   = 1'b0;
        start_conv = 1'b0;
        frame_end  = 1'b0;
        case (mstate_q)
            WAIT_RISE: load_cnt = rise;
            MEAS_HIGH: start_conv = fall;
            MEAS_LOW: begin
                load_cnt  = rise;
                frame_end = rise;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            hcnt_q <= '0;
            pcnt_q <= '0;
            tcnt_q <= '0;
            hlat_q <= '0;
        end else begin
            if (load_cnt) begin
                hcnt_q <= CW'(1);
                pcnt_q <= CW'(1);
            end else if (mstate_q != WAIT_RISE) begin
                if (mstate_q == MEAS_HIGH) hcnt_q <= hcnt_q + 1'b1;
                if (pcnt_q != '1) pcnt_q <= pcnt_q + 1'b1;
            end
            tcnt_q <= (mstate_d == WAIT_RISE || rise || fall) ? '0 : tcnt_q + 1'b1;
            if (start_conv) hlat_q <= hcnt_q;
        end
    end

    // Angle converter: one subtraction of STEP per cycle, quotient capped at 180.
    assign w_low  = hcnt_q < CW'(MIN_WIDTH);
    assign w_high = hcnt_q > CW'(MAX_WIDTH);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) cstate_q <= C_IDLE;
        else      cstate_q <= cstate_d;
    end

    always_comb begin
        cstate_d = cstate_q;
        if (start_conv)                          cstate_d = (w_low || w_high) ? C_DONE : C_DIV;
        else if (frame_end || tmo_hit)           cstate_d = C_IDLE;
        else if (cstate_q == C_DIV && !div_step) cstate_d = C_DONE;
    end

    always_comb begin
        div_step  = (cstate_q == C_DIV) && (rem_q >= CW'(STEP)) && (quo_q != 8'd180);
        conv_done = (cstate_q == C_DONE);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rem_q  <= '0;
            quo_q  <= '0;
            cerr_q <= 1'b0;
        end else if (start_conv) begin
            rem_q  <= hcnt_q - CW'(MIN_WIDTH);
            quo_q  <= w_high ? 8'd180 : 8'd0;
            cerr_q <= w_low | w_high;
        end else if (div_step) begin
            rem_q <= rem_q - CW'(STEP);
            quo_q <= quo_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            width_q  <= '0;
            period_q <= '0;
            angle_q  <= '0;
            valid_q  <= 1'b0;
            rerr_q   <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            valid_q <= frame_end && conv_done;
            if (frame_end && conv_done) begin
                width_q  <= hlat_q;
                period_q <= pcnt_q;
                angle_q  <= {1'b0, quo_q};
                rerr_q   <= cerr_q;
                tmo_q    <= 1'b0;
            end else if (tmo_hit) begin
                tmo_q <= 1'b1;
            end
        end
    end

    assign width     = width_q;
    assign period    = period_q;
    assign angle     = angle_q;
    assign valid     = valid_q;
    assign range_err = rerr_q;
    assign timeout   = tmo_q;
endmodule

// File: tb/tb_servo_pwm_capture.sv
// Directed bench for servo_pwm_capture with a scaled-down timing set and a result scoreboard.
module tb_servo_pwm_capture;
    localparam int MINW = 200;
    localparam int MAXW = 560;
    localparam int STEPC = 2;
    localparam int TMO = 2000;
    localparam int FLEN = 4;

    logic clk = 1'b0;
    logic clr = 1'b0;
    logic pwm_in = 1'b0;
    logic [21:0] width, period;
    logic [8:0] angle;
    logic valid, range_err, timeout;

    typedef struct {
        int w;
        int p;
        int a;
        int e;
    } exp_t;
    exp_t sbq[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    servo_pwm_capture #(
        .MIN_WIDTH(MINW), .MAX_WIDTH(MAXW), .STEP(STEPC),
        .TIMEOUT(TMO), .FILTER_LEN(FLEN)
    ) dut (
        .clk(clk), .clr(clr), .pwm_in(pwm_in),
        .width(width), .period(period), .angle(angle),
        .valid(valid), .range_err(range_err), .timeout(timeout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic int model_angle(input int w);
        int a;
        if (w < MINW) return 0;
        if (w > MAXW) return 180;
        a = (w - MINW) / STEPC;
        return (a > 180) ? 180 : a;
    endfunction

    task automatic push(input int w, input int p);
        exp_t e;
        e.w = w;
        e.p = p;
        e.a = model_angle(w);
        e.e = (w < MINW || w > MAXW) ? 1 : 0;
        sbq.push_back(e);
    endtask

    task automatic hold(input logic lvl, input int n);
        pwm_in = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input int hi, input int lo, input bit expect_valid);
        if (expect_valid) push(hi, hi + lo);
        hold(1'b1, hi);
        hold(1'b0, lo);
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 60 && sbq.size() > 0; i++) @(posedge clk);
        #1;
        chk("queue_drained", sbq.size(), 0);
    endtask

    // Result monitor: every valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (clr && valid) begin
            checks++;
            assert (sbq.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_valid got width=%0d period=%0d expected no valid", width, period);
            end
            if (sbq.size() > 0) begin
                exp_t e;
                e = sbq.pop_front();
                chk("width", width, e.w);
                chk("period", period, e.p);
                chk("angle", angle, e.a);
                chk("range_err", range_err, e.e);
            end
            chk("timeout_on_valid", timeout, 0);
        end
    end

    initial begin
        // Reset with the input already high: release must not start a frame.
        clr = 1'b0;
        pwm_in = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_width", width, 0);
        chk("rst_period", period, 0);
        chk("rst_angle", angle, 0);
        chk("rst_valid", valid, 0);
        chk("rst_range_err", range_err, 0);
        chk("rst_timeout", timeout, 0);
        clr = 1'b1;
        hold(1'b1, 40);
        hold(1'b0, 300);

        // Back-to-back nominal frames.
        frame(380, 620, 1);
        frame(380, 620, 1);
        frame(380, 620, 1);

        // Boundary widths.
        frame(200, 800, 1);
        frame(560, 440, 1);
        frame(199, 801, 1);
        frame(700, 300, 1);

        // Low phase too short for the converter: frame is dropped.
        frame(560, 100, 0);
        frame(380, 620, 1);

        // Two-cycle glitch in the low phase.
`ifdef SERVO_CAPTURE_GLITCH_FILTER_EN
        push(380, 1000);
`else
        push(380, 680);
        push(2, 320);
`endif
        hold(1'b1, 380);
        hold(1'b0, 300);
        hold(1'b1, 2);
        hold(1'b0, 318);
        frame(380, 620, 1);

        // Reset in the middle of a high phase.
        hold(1'b1, 100);
        wait_empty();
        clr = 1'b0;
        #1;
        chk("midrst_width", width, 0);
        chk("midrst_period", period, 0);
        chk("midrst_angle", angle, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_range_err", range_err, 0);
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b1;
        hold(1'b1, 200);
        hold(1'b0, 500);
        push(380, 1000);
        hold(1'b1, 380);
        chk("first_edge_no_valid", sbq.size(), 1);
        hold(1'b0, 620);

        // Loss of signal, then recovery.
        frame(380, 620, 1);
        hold(1'b1, 380);
        hold(1'b0, TMO - 100);
        chk("timeout_not_early", timeout, 0);
        hold(1'b0, 120);
        chk("timeout_set", timeout, 1);
        chk("timeout_no_pending", sbq.size(), 0);
        frame(380, 620, 1);
        hold(1'b1, 50);
        wait_empty();
        chk("timeout_cleared", timeout, 0);
        hold(1'b0, 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
